arm_data_path: RTL and testbench
================================

Name: arm_data_path

Overview:
- Single-cycle datapath for a 32-bit ARM-subset CPU.
- Each clock it takes the instruction word fetched at pc from external instruction memory and decodes it.
- It reads the register file and computes with the ALU.
- It drives the external data memory (combinational read, write on clock edge), then updates the registers, NZCV flags and pc.
- Control decode is internal; no separate controller block.

Parameters:
- RESET_PC, 32'h0000_0000: pc value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr  input  32  instruction at current pc.
- read_data  input  32  data memory read data, combinational from addr_data.
- pc  output  32  current program counter, registered.
- addr_data  output  32  data memory address, equal to the ALU result.
- write_data  output  32  store data, equal to the register file value of Rd.
- we  output  1  data memory write enable.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; R0–R14=0; NZCV=0.
  - we forced 0 while reset is asserted.
- Execution: every instruction completes in 1 cycle; pc_next defaults to pc+4.
- Register reads: reading R15 returns pc+8.
- Condition field instr[31:28]: standard ARM codes EQ..AL against the current flags. A failing condition makes the instruction a NOP: no register write, no flag update, we=0, pc+4.
- Data processing (instr[27:26]=00, not BX):
  - I=instr[25], cmd=instr[24:21], S=instr[20], Rn=[19:16], Rd=[15:12].
  - Immediate operand: imm8=instr[7:0] rotated right by 2*instr[11:8].
  - Register operand: Rm=instr[3:0].
  - Supported cmds: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, TST 1000, CMP 1010, ORR 1100, MOV 1101, BIC 1110, MVN 1111. Other cmds are NOPs.
  - Write-back to Rd for all supported cmds except TST/CMP.
  - Flags update when S=1, or always for TST/CMP:
    - N = result[31]; Z = (result==0).
    - C = carry-out for ADD; NOT borrow for SUB/CMP/RSB; shifter carry for logic ops.
    - V = signed overflow for add/sub; unchanged for logic ops.
- Memory (instr[27:26]=01): STR when L=instr[20]=0, LDR when L=1.
  - addr_data = Rn + imm12 if U=instr[23]=1, else Rn − imm12. Offset addressing only; P and W are ignored.
  - STR: we=1, write_data=Rd.
  - LDR: Rd ← read_data at the clock edge.
- Branch (instr[27:26]=10):
  - pc_next = pc+8 + (sign-extended imm24 << 2).
  - If instr[24]=1 (BL), also R14 ← pc+4.
- BX: instr[27:20]=8'h12, bits[19:4] ignored; pc_next = R[instr[3:0]].
- Writes to Rd=15 through data processing or LDR load pc instead of a register.
- addr_data and write_data always reflect the current decode, even when we=0.
- Simultaneous register write and read of the same register: reads return the old value (write at the edge).

Optional Feature:
- Macro DATA_PATH_SHIFT_EN.
- Defined: the register operand of data-processing instructions passes through a barrel shifter:
  - sh=instr[6:5] selects LSL/LSR/ASR/ROR; amount instr[11:7].
  - Amount 0 with LSR/ASR means 32; ROR #0 means RRX.
  - The shifter carry feeds C for logic ops.
- Undefined: the register operand is Rm unshifted; bits[11:4] are ignored; logic ops leave C unchanged.

Test Plan:
- Reset and pc advance:
  - Hold reset=0 → pc=0, we=0.
  - Release with instr=0xE1A00000 (NOP MOV r0,r0) → pc reads 4, 8, 12 on successive edges.
- Immediate arithmetic:
  - 0xE3A03002 (MOV r3,#2), then 0xE2833001 (ADD r3,r3,#1), then 0xE5853008 (STR r3,[r5,#8]).
  - Required: addr_data=8, write_data=3, we=1.
- Load:
  - 0xE5954008 (LDR r4,[r5,#8]) with read_data=0x55, then 0xE5854000 (STR r4,[r5]).
  - Required: write_data=0x55, addr_data=0.
- Conditional execution:
  - r3=3, then 0xE2533003 (SUBS r3,r3,#3) → Z=1, C=1.
  - Then 0x13A06005 (MOVNE r6,#5) → skipped; then 0x03A06007 (MOVEQ r6,#7) → executed.
  - Required: a subsequent STR of r6 outputs write_data=7.
- Branching:
  - At pc=0x20, 0xEA000001 (B) → pc=0x2C.
  - At pc=P, 0xEB000000 (BL) → pc=P+8, r14=P+4.
  - Then 0xE12FFF1E (BX r14) → pc=P+4.
- Async reset mid-run: drive reset=0 between clock edges after the branch test → pc=0 and we=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arm_data_path.sv
// Single-cycle datapath for a 32-bit ARM subset: decode, register file, ALU, memory port, NZCV and pc.
// Define DATA_PATH_SHIFT_EN to route the data-processing register operand through a barrel shifter.
module arm_data_path #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    output logic [31:0] pc,
    output logic [31:0] addr_data,
    output logic [31:0] write_data,
    output logic        we
);
    localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010, CMD_RSB = 4'b0011,
                           CMD_ADD = 4'b0100, CMD_TST = 4'b1000, CMD_CMP = 4'b1010, CMD_ORR = 4'b1100,
                           CMD_MOV = 4'b1101, CMD_BIC = 4'b1110, CMD_MVN = 4'b1111;

    logic [31:0] rf [0:14];
    logic        flag_n, flag_z, flag_c, flag_v;

    logic [31:0] pc_plus4, pc_plus8;
    logic [3:0]  cond, cmd, rn_idx, rd_idx, rm_idx;
    logic        is_bx, is_dp, is_mem, is_br, cond_pass;
    logic [31:0] rn_val, rd_val, rm_val;

    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc + 32'd8;
    assign cond     = instr[31:28];
    assign cmd      = instr[24:21];
    assign rn_idx   = instr[19:16];
    assign rd_idx   = instr[15:12];
    assign rm_idx   = instr[3:0];
    assign is_bx    = (instr[27:20] == 8'h12);
    assign is_dp    = (instr[27:26] == 2'b00) && !is_bx;
    assign is_mem   = (instr[27:26] == 2'b01);
    assign is_br    = (instr[27:26] == 2'b10);

    // R15 is not stored; reading it yields the pipeline-visible pc+8.
    assign rn_val = (rn_idx == 4'hF) ? pc_plus8 : rf[rn_idx];
    assign rd_val = (rd_idx == 4'hF) ? pc_plus8 : rf[rd_idx];
    assign rm_val = (rm_idx == 4'hF) ? pc_plus8 : rf[rm_idx];

    always_comb begin
        case (cond)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Immediate operand: imm8 rotated right by twice the 4-bit rotate field.
    logic [31:0] imm_ext, imm_rot;
    logic [4:0]  rot_amt;
    logic        imm_carry;
    assign imm_ext   = {24'd0, instr[7:0]};
    assign rot_amt   = {instr[11:8], 1'b0};
    assign imm_rot   = (imm_ext >> rot_amt) | (imm_ext << (6'd32 - {1'b0, rot_amt}));
    assign imm_carry = (rot_amt == 5'd0) ? flag_c : imm_rot[31];

    logic [31:0] sh_out;
    logic        sh_carry;
`ifdef DATA_PATH_SHIFT_EN
    logic [4:0]  sh_amt;
    logic [32:0] sh_tmp;
    assign sh_amt = instr[11:7];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sh_tmp   = '0;
        sh_out   = rm_val;
        sh_carry = flag_c;
        case (instr[6:5])
            2'b00: if (sh_amt != 5'd0) begin
                sh_tmp   = {1'b0, rm_val} << sh_amt;
                sh_out   = sh_tmp[31:0];
                sh_carry = sh_tmp[32];
            end
            2'b01: if (sh_amt == 5'd0) begin
                sh_out   = '0;
                sh_carry = rm_val[31];
            end else begin
                sh_tmp   = {rm_val, 1'b0} >> sh_amt;
                sh_out   = sh_tmp[32:1];
                sh_carry = sh_tmp[0];
            end
            2'b10: if (sh_amt == 5'd0) begin
                sh_out   = {32{rm_val[31]}};
                sh_carry = rm_val[31];
            end else begin
                sh_tmp   = $signed({rm_val, 1'b0}) >>> sh_amt;
                sh_out   = sh_tmp[32:1];
                sh_carry = sh_tmp[0];
            end
            default: if (sh_amt == 5'd0) begin
                sh_out   = {flag_c, rm_val[31:1]};
                sh_carry = rm_val[0];
            end else begin
                sh_out   = (rm_val >> sh_amt) | (rm_val << (6'd32 - {1'b0, sh_amt}));
                sh_carry = sh_out[31];
            end
        endcase
    end
`else
    assign sh_out   = rm_val;
    assign sh_carry = flag_c;
`endif

    logic [31:0] op2;
    logic        op2_carry;
    assign op2       = instr[25] ? imm_rot : sh_out;
    assign op2_carry = instr[25] ? imm_carry : sh_carry;

    // Subtractions reuse one adder as a + ~b + 1, so carry-out is NOT borrow.
    logic [31:0] add_a, add_b;
    logic        add_cin, add_v, is_arith, is_test, dp_ok;
    logic [32:0] add_res;
    logic [31:0] dp_result;

    always_comb begin
        add_a   = rn_val;
        add_b   = op2;
        add_cin = 1'b0;
        if (cmd == CMD_SUB || cmd == CMD_CMP) begin
            add_b   = ~op2;
            add_cin = 1'b1;
        end else if (cmd == CMD_RSB) begin
            add_a   = op2;
            add_b   = ~rn_val;
            add_cin = 1'b1;
        end
    end

    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    assign add_v    = (add_a[31] == add_b[31]) && (add_res[31] != add_a[31]);
    assign is_arith = (cmd == CMD_SUB) || (cmd == CMD_RSB) || (cmd == CMD_ADD) || (cmd == CMD_CMP);
    assign is_test  = (cmd == CMD_TST) || (cmd == CMD_CMP);

    always_comb begin
        dp_ok = 1'b1;
        case (cmd)
            CMD_AND, CMD_TST:                  dp_result = rn_val & op2;
            CMD_EOR:                           dp_result = rn_val ^ op2;
            CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP: dp_result = add_res[31:0];
            CMD_ORR:                           dp_result = rn_val | op2;
            CMD_MOV:                           dp_result = op2;
            CMD_BIC:                           dp_result = rn_val & ~op2;
            CMD_MVN:                           dp_result = ~op2;
            default: begin
                dp_result = '0;
                dp_ok     = 1'b0;
            end
        endcase
    end

    logic [31:0] mem_addr;
    assign mem_addr   = instr[23] ? rn_val + {20'd0, instr[11:0]} : rn_val - {20'd0, instr[11:0]};
    assign addr_data  = is_mem ? mem_addr : dp_result;
    assign write_data = rd_val;
    assign we         = reset && cond_pass && is_mem && !instr[20];

    logic [31:0] pc_next, rf_wdata;
    logic [3:0]  rf_widx;
    logic        rf_we, flags_we;

    always_comb begin
        pc_next  = pc_plus4;
        rf_we    = 1'b0;
        rf_widx  = rd_idx;
        rf_wdata = dp_result;
        flags_we = 1'b0;
        if (cond_pass) begin
            if (is_bx) begin
                pc_next = rm_val;
            end else if (is_dp && dp_ok) begin
                if (!is_test) begin
                    if (rd_idx == 4'hF) pc_next = dp_result;
                    else                rf_we   = 1'b1;
                end
                flags_we = instr[20] || is_test;
            end else if (is_mem && instr[20]) begin
                rf_wdata = read_data;
                if (rd_idx == 4'hF) pc_next = read_data;
                else                rf_we   = 1'b1;
            end else if (is_br) begin
                pc_next = pc_plus8 + {{6{instr[23]}}, instr[23:0], 2'b00};
                if (instr[24]) begin
                    rf_we    = 1'b1;
                    rf_widx  = 4'd14;
                    rf_wdata = pc_plus4;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            // NOTE: the register file is architecturally cleared on reset, so it is reset like flops.
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (rf_we) rf[rf_widx] <= rf_wdata;
            if (flags_we) begin
                flag_n <= dp_result[31];
                flag_z <= (dp_result == 32'd0);
                flag_c <= is_arith ? add_res[32] : op2_carry;
                flag_v <= is_arith ? add_v : flag_v;
            end
        end
    end
endmodule

// File: tb/tb_arm_data_path.sv
// Directed bench for arm_data_path: expected values queue on drive and are popped at each comparison.
module tb_arm_data_path;
    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic [31:0] pc;
    logic [31:0] addr_data;
    logic [31:0] write_data;
    logic        we;

    arm_data_path dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .read_data  (read_data),
        .pc         (pc),
        .addr_data  (addr_data),
        .write_data (write_data),
        .we         (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    task automatic expect_v(input string tag, input logic [31:0] value);
        sb.push_back('{tag, value});
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // Present one instruction mid-cycle; the next rising edge executes it.
    task automatic drive(input logic [31:0] i, input logic [31:0] rd);
        @(negedge clk);
        instr     = i;
        read_data = rd;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        instr     = 32'hE585_3008;
        read_data = 32'd0;
        @(negedge clk);
        @(negedge clk);
        expect_v("reset_pc", 32'h0);         check(pc);
        expect_v("reset_we", 32'h0);         check({31'd0, we});

        @(negedge clk);
        reset = 1'b1;
        instr = NOP;
        #1;
        drive(NOP, 32'd0);
        expect_v("pc_adv_4", 32'd4);         check(pc);
        drive(NOP, 32'd0);
        expect_v("pc_adv_8", 32'd8);         check(pc);
        drive(32'hE3A0_3002, 32'd0);         // MOV r3,#2
        expect_v("pc_adv_12", 32'd12);       check(pc);
        drive(32'hE283_3001, 32'd0);         // ADD r3,r3,#1
        drive(32'hE585_3008, 32'd0);         // STR r3,[r5,#8]
        expect_v("str_addr", 32'd8);         check(addr_data);
        expect_v("str_wdata", 32'd3);        check(write_data);
        expect_v("str_we", 32'd1);           check({31'd0, we});

        drive(32'hE595_4008, 32'h55);        // LDR r4,[r5,#8]
        expect_v("ldr_addr", 32'd8);         check(addr_data);
        expect_v("ldr_we", 32'd0);           check({31'd0, we});
        drive(32'hE585_4000, 32'd0);         // STR r4,[r5]
        expect_v("ldr_wdata", 32'h55);       check(write_data);
        expect_v("ldr_str_addr", 32'd0);     check(addr_data);

        drive(32'hE253_3003, 32'd0);         // SUBS r3,r3,#3 -> Z=1 C=1
        expect_v("subs_result", 32'd0);      check(addr_data);
        drive(32'h13A0_6005, 32'd0);         // MOVNE r6,#5 (skipped)
        drive(32'h03A0_6007, 32'd0);         // MOVEQ r6,#7
        drive(32'h23A0_7001, 32'd0);         // MOVCS r7,#1
        drive(32'hE585_6000, 32'd0);         // STR r6
        expect_v("cond_eq_r6", 32'd7);       check(write_data);
        drive(32'hE585_7000, 32'd0);         // STR r7
        expect_v("cond_cs_r7", 32'd1);       check(write_data);

        drive(32'hE084_9004, 32'd0);         // ADD r9,r4,r4
        drive(32'hE585_9000, 32'd0);         // STR r9
        expect_v("add_reg", 32'hAA);         check(write_data);
        drive(32'hE3A0_C4FF, 32'd0);         // MOV r12,#0xFF000000
        drive(32'hE585_C000, 32'd0);         // STR r12
        expect_v("imm_rotate", 32'hFF00_0000); check(write_data);

        drive(32'hE255_A001, 32'd0);         // SUBS r10,r5,#1 -> N=1 C=0
        expect_v("subs_neg", 32'hFFFF_FFFF); check(addr_data);
        drive(32'h23A0_B004, 32'd0);         // MOVCS r11,#4 (skipped)
        expect_v("nop_we", 32'd0);           check({31'd0, we});
        drive(32'h43A0_B009, 32'd0);         // MOVMI r11,#9
        drive(32'hE585_B000, 32'd0);         // STR r11
        expect_v("cond_mi_r11", 32'd9);      check(write_data);

        drive(32'hE585_F000, 32'd0);         // STR r15
        expect_v("pc_at_str15", 32'd88);     check(pc);
        expect_v("r15_read", 32'd96);        check(write_data);
        drive(32'hE505_3008, 32'd0);         // STR r3,[r5,#-8]
        expect_v("addr_down", 32'hFFFF_FFF8); check(addr_data);
        expect_v("wdata_r3", 32'd0);         check(write_data);

        drive(32'hE3A0_8020, 32'd0);         // MOV r8,#0x20
        drive(32'hE12F_FF18, 32'd0);         // BX r8
        drive(32'hEA00_0001, 32'd0);         // B at 0x20
        expect_v("bx_r8_pc", 32'h20);        check(pc);
        drive(32'hEB00_0000, 32'd0);         // BL at 0x2C
        expect_v("b_pc", 32'h2C);            check(pc);
        drive(32'hE585_E000, 32'd0);         // STR r14
        expect_v("bl_pc", 32'h34);           check(pc);
        expect_v("bl_r14", 32'h30);          check(write_data);
        drive(32'hE12F_FF1E, 32'd0);         // BX r14
        drive(32'hE585_3008, 32'd0);         // STR, to make we=1 before reset
        expect_v("bx_r14_pc", 32'h30);       check(pc);
        expect_v("pre_reset_we", 32'd1);     check({31'd0, we});

        #1 reset = 1'b0;
        #1;
        expect_v("async_pc", 32'h0);         check(pc);
        expect_v("async_we", 32'h0);         check({31'd0, we});

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
